// File: rtl/gpu_pkg.sv
// Shared rasterizer types: the packed triangle descriptor, framebuffer
// geometry and the frame sequencer state encoding.
package gpu_pkg;

  typedef struct packed {
    logic        [31:0] inv_area;
    logic        [7:0]  color;
    logic signed [9:0]  a1;
    logic signed [9:0]  a2;
    logic signed [9:0]  a3;
    logic signed [9:0]  b1;
    logic signed [9:0]  b2;
    logic signed [9:0]  b3;
    logic signed [17:0] c1;
    logic signed [17:0] c2;
    logic signed [17:0] c3;
    logic        [8:0]  bbxi;
    logic        [8:0]  bbxf;
    logic        [7:0]  bbyi;
    logic        [7:0]  bbyf;
    logic        [15:0] z1;
    logic        [15:0] z2;
    logic        [15:0] z3;
  } tri_desc_t;

  localparam int TRI_DESC_W = $bits(tri_desc_t);
  localparam int FB_W       = 320;
  localparam int FB_H       = 240;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } seq_state_e;

  // Triangle counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tri_desc_fifo.sv
// Synchronous first-word-fall-through FIFO for triangle descriptors.
// Ports: push_i/push_data_i write side (ignored when full), pop_i read side
// (ignored when empty), pop_data_o shows the head entry, full_o/empty_o flags.
// rst (async, active-high) flushes the queue.
module tri_desc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/raster_frame_sequencer.sv
// Frame-level rasterizer controller. Queues triangle descriptors from the
// host, optionally clears the framebuffer at frame start, then launches the
// rasterizer one triangle at a time over its start/done handshake and muxes
// the single framebuffer write port between the clear engine and rasterizer.
// Ports:
//   tri_valid/tri_ready/tri_desc   descriptor push (accepted on valid&ready)
//   frame_start/frame_end/bg_color frame control from the host
//   frame_busy/frame_done/tri_count frame status
//   rast_start/rast_done/rast_desc rasterizer launch handshake
//   rast_fb_*                      rasterizer framebuffer write request
//   fb_*                           framebuffer write port
// Build option: define FB_CLEAR_EN to include the background clear pass;
// without it frame_start goes straight to fetching and bg_color is unused.
module raster_frame_sequencer
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FB_WORDS   = 76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  tri_desc_t   tri_desc,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic [7:0]  bg_color,
  output logic        frame_busy,
  output logic        frame_done,
  output logic [15:0] tri_count,
  output logic        rast_start,
  input  logic        rast_done,
  output tri_desc_t   rast_desc,
  input  logic        rast_fb_we,
  input  logic [16:0] rast_fb_addr,
  input  logic [7:0]  rast_fb_din,
  output logic        fb_we,
  output logic [16:0] fb_addr,
  output logic [7:0]  fb_din
);

  seq_state_e  state_q, state_d;
  logic        end_q, end_d;
  logic [15:0] count_q, count_d;
  tri_desc_t   desc_q, desc_d;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  tri_desc_t   fifo_head;

`ifdef FB_CLEAR_EN
  localparam logic [16:0] CLR_LAST = 17'(FB_WORDS - 1);
  logic [7:0]  bg_q, bg_d;
  logic [16:0] clr_q, clr_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{bg_color, 17'(FB_WORDS)};
`endif

  tri_desc_fifo #(
    .WIDTH(TRI_DESC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (tri_valid),
    .push_data_i(tri_desc),
    .pop_i      (fifo_pop),
    .pop_data_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign tri_ready  = !fifo_full;
  assign frame_busy = (state_q != S_IDLE);
  assign tri_count  = count_q;
  assign rast_desc  = desc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      end_q   <= 1'b0;
      count_q <= '0;
      desc_q  <= '0;
`ifdef FB_CLEAR_EN
      bg_q    <= '0;
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      end_q   <= end_d;
      count_q <= count_d;
      desc_q  <= desc_d;
`ifdef FB_CLEAR_EN
      bg_q    <= bg_d;
      clr_q   <= clr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    end_d      = end_q;
    count_d    = count_q;
    desc_d     = desc_q;
    fifo_pop   = 1'b0;
    rast_start = 1'b0;
    frame_done = 1'b0;
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_din     = '0;
`ifdef FB_CLEAR_EN
    bg_d       = bg_q;
    clr_d      = clr_q;
`endif

    // Sticky end flag; may be set in the same cycle as a pop.
    if (frame_busy && frame_end) end_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          end_d   = 1'b0;
          count_d = '0;
`ifdef FB_CLEAR_EN
          bg_d    = bg_color;
          clr_d   = '0;
          state_d = S_CLEAR;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef FB_CLEAR_EN
      S_CLEAR: begin
        fb_we   = 1'b1;
        fb_addr = clr_q;
        fb_din  = bg_q;
        if (clr_q == CLR_LAST) state_d = S_FETCH;
        else                   clr_d   = clr_q + 17'd1;
      end
`endif
      S_FETCH: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          desc_d   = fifo_head;
          state_d  = S_LAUNCH;
        end else if (end_q) begin
          state_d  = S_DONE;
        end
      end
      S_LAUNCH: begin
        rast_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        fb_we   = rast_fb_we;
        fb_addr = rast_fb_addr;
        fb_din  = rast_fb_din;
        if (rast_done) begin
          count_d = sat_inc16(count_q);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_raster_frame_sequencer.sv
module tb_raster_frame_sequencer;
  import gpu_pkg::*;

  localparam int CLR_WORDS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        tri_valid;
  logic        tri_ready;
  tri_desc_t   tri_desc;
  logic        frame_start;
  logic        frame_end;
  logic [7:0]  bg_color;
  logic        frame_busy;
  logic        frame_done;
  logic [15:0] tri_count;
  logic        rast_start;
  logic        rast_done;
  tri_desc_t   rast_desc;
  logic        rast_fb_we;
  logic [16:0] rast_fb_addr;
  logic [7:0]  rast_fb_din;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [7:0]  fb_din;

  raster_frame_sequencer #(
    .FIFO_DEPTH(8),
    .FB_WORDS  (CLR_WORDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tri_valid   (tri_valid),
    .tri_ready   (tri_ready),
    .tri_desc    (tri_desc),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .bg_color    (bg_color),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .tri_count   (tri_count),
    .rast_start  (rast_start),
    .rast_done   (rast_done),
    .rast_desc   (rast_desc),
    .rast_fb_we  (rast_fb_we),
    .rast_fb_addr(rast_fb_addr),
    .rast_fb_din (rast_fb_din),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_din      (fb_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  tri_desc_t exp_q[$];
  int        done_q[$];
  int        tests = 0;
  int        fails = 0;

  // Frame / rasterizer model state
  bit        in_wait = 0;
  bit        first_wait = 0;
  int        wait_left = 0;
  tri_desc_t cur_desc;
  int        launches = 0;
  int        last_done_cyc = -100;
  int        done_cyc = 0;
  int        done_seen = 0;
  bit        strict_lat = 0;
  int        start_cyc = 0;
  int        frame_exp = 0;
  int        last_cnt = 0;
  bit        in_frame = 0;
`ifdef FB_CLEAR_EN
  bit        clr_pending = 0;
  int        clr_left = 0;
  int        clr_addr = 0;
  logic [7:0] clr_bg;
  int        last_clr_cyc = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_desc(input string name, input tri_desc_t act, input tri_desc_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic tri_desc_t rand_desc();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return tri_desc_t'(r[TRI_DESC_W-1:0]);
  endfunction

  // Rasterizer model plus output monitor: drives rast_* each cycle and
  // checks fb_*, launches and frame completion against the scoreboard.
  initial begin : rast_model
    rast_done    = 1'b0;
    rast_fb_we   = 1'b0;
    rast_fb_addr = '0;
    rast_fb_din  = '0;
    forever begin
      @(posedge clk); #1;
`ifdef FB_CLEAR_EN
      if (clr_pending) begin
        clr_pending = 0;
        clr_left    = CLR_WORDS;
        clr_addr    = 0;
      end
`endif
      if (in_wait) begin
        rast_done = (wait_left == 0);
        if (first_wait) begin
          rast_fb_we   = 1'b1;
          rast_fb_addr = 17'd321;
          rast_fb_din  = 8'hE0;
          first_wait   = 0;
        end else begin
          rast_fb_we   = 1'($urandom);
          rast_fb_addr = 17'($urandom_range(0, 76799));
          rast_fb_din  = 8'($urandom);
        end
        if (wait_left > 0) wait_left--;
      end else begin
        rast_done    = ($urandom_range(0, 3) == 0);
        rast_fb_we   = 1'b1;
        rast_fb_addr = 17'($urandom_range(0, 76799));
        rast_fb_din  = 8'($urandom);
      end
      @(negedge clk);
      if (rst) begin
        in_wait = 0;
`ifdef FB_CLEAR_EN
        clr_left = 0;
`endif
        continue;
      end
      if (in_wait) begin
        chk("fb_we_pass", 32'(fb_we), 32'(rast_fb_we));
        chk("fb_addr_pass", 32'(fb_addr), 32'(rast_fb_addr));
        chk("fb_din_pass", 32'(fb_din), 32'(rast_fb_din));
        chk_desc("rast_desc_hold", rast_desc, cur_desc);
      end
`ifdef FB_CLEAR_EN
      else if (clr_left > 0) begin
        chk("clr_we", 32'(fb_we), 32'd1);
        chk("clr_addr", 32'(fb_addr), 32'(clr_addr));
        chk("clr_din", 32'(fb_din), 32'(clr_bg));
        clr_addr++;
        clr_left--;
        if (clr_left == 0) last_clr_cyc = cyc;
      end
`endif
      else begin
        chk("fb_we_blocked", 32'(fb_we), 32'd0);
      end
      if (in_wait && rast_done) begin
        in_wait       = 0;
        last_done_cyc = cyc;
      end
      if (rast_start) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL launch: unexpected rast_start got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          cur_desc = exp_q.pop_front();
          chk_desc("rast_desc", rast_desc, cur_desc);
        end
        if (strict_lat && launches > 0) chk("launch_gap", 32'(cyc - last_done_cyc), 32'd2);
        launches++;
        in_wait    = 1;
        first_wait = 1;
        wait_left  = $urandom_range(0, 4);
      end
      if (frame_done) begin
        done_seen++;
        done_cyc = cyc;
        if (done_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL frame_done: unexpected pulse got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("tri_count_at_done", 32'(tri_count), 32'(done_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input tri_desc_t d, input logic exp_acc);
    tri_desc  = d;
    tri_valid = 1'b1;
    @(negedge clk);
    chk("tri_ready", 32'(tri_ready), 32'(exp_acc));
    if (exp_acc) begin
      exp_q.push_back(d);
      if (in_frame) frame_exp++;
    end
    tick();
    tri_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] bg);
    bg_color    = bg;
    frame_start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    frame_exp = exp_q.size();
    launches  = 0;
    in_frame  = 1;
`ifdef FB_CLEAR_EN
    clr_bg      = bg;
    clr_pending = 1;
`endif
    tick();
    frame_start = 1'b0;
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    @(negedge clk);
    chk("frame_busy_active", 32'(frame_busy), 32'd1);
    done_q.push_back(frame_exp);
    last_cnt = frame_exp;
    in_frame = 0;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_q.size() > 0 && n < 5000) begin
      tick();
      n++;
    end
    if (done_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL frame_done_timeout: got no pulse expected one within 5000 cycles");
      done_q.delete();
    end
    repeat (3) tick();
    @(negedge clk);
    chk("frame_busy_after_done", 32'(frame_busy), 32'd0);
    chk("tri_count_hold", 32'(tri_count), 32'(last_cnt));
    tick();
  endtask

  task automatic wait_in_wait(input int target);
    int n = 0;
    while (!(in_wait && launches == target) && n < 2000) begin
      tick();
      n++;
    end
    if (!(in_wait && launches == target)) begin
      tests++;
      fails++;
      $display("FAIL wait_state_timeout: got launches %0d expected %0d in WAIT", launches, target);
    end
  endtask

  initial begin : main
    int saved;
    rst         = 1'b1;
    tri_valid   = 1'b0;
    tri_desc    = '0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    bg_color    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tri_ready", 32'(tri_ready), 32'd1);
    chk("rst_frame_busy", 32'(frame_busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_tri_count", 32'(tri_count), 32'd0);
    chk("rst_rast_start", 32'(rast_start), 32'd0);
    chk_desc("rst_rast_desc", rast_desc, '0);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Empty frame: clear only (when built) then immediate completion.
    start_frame(8'h1C);
    end_frame();
    wait_done();
`ifdef FB_CLEAR_EN
    chk("done_latency", 32'(done_cyc - start_cyc), 32'(CLR_WORDS + 2));
    chk("done_after_clear", 32'(done_cyc - last_clr_cyc), 32'd2);
`else
    chk("done_latency", 32'(done_cyc - start_cyc), 32'd3);
`endif

    // Three triangles queued while idle; back-to-back launches.
    strict_lat = 1;
    repeat (3) push(rand_desc(), 1'b1);
    start_frame(8'($urandom));
    end_frame();
    wait_done();

    // Overfill: ninth push refused, exactly eight launches.
    for (int i = 0; i < 9; i++) push(rand_desc(), (i < 8) ? 1'b1 : 1'b0);
    start_frame(8'($urandom));
    end_frame();
    wait_done();
    chk("overfill_launches", 32'(launches), 32'd8);
    strict_lat = 0;

    // Reset while the second of four triangles is rasterizing.
    repeat (4) push(rand_desc(), 1'b1);
    start_frame(8'($urandom));
    end_frame();
    wait_in_wait(2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tri_ready", 32'(tri_ready), 32'd1);
    chk("midrst_frame_busy", 32'(frame_busy), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_tri_count", 32'(tri_count), 32'd0);
    chk("midrst_rast_start", 32'(rast_start), 32'd0);
    chk_desc("midrst_rast_desc", rast_desc, '0);
    chk("midrst_fb_we", 32'(fb_we), 32'd0);
    exp_q.delete();
    done_q.delete();
    in_frame = 0;
    tick();
    rst = 1'b0;
    tick();
    repeat (2) push(rand_desc(), 1'b1);
    start_frame(8'($urandom));
    end_frame();
    wait_done();

    // frame_start mid-frame and frame_end while idle are both ignored.
    repeat (3) push(rand_desc(), 1'b1);
    start_frame(8'($urandom));
    wait_in_wait(1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    end_frame();
    wait_done();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    repeat (2) push(rand_desc(), 1'b1);
    saved = done_seen;
    start_frame(8'($urandom));
    repeat (60 + CLR_WORDS) tick();
    @(negedge clk);
    chk("no_done_without_end", 32'(done_seen), 32'(saved));
    chk("busy_without_end", 32'(frame_busy), 32'd1);
    tick();
    end_frame();
    wait_done();

    // Randomized frames with pre-queued and in-frame pushes.
    for (int f = 0; f < 6; f++) begin
      int n;
      int m;
      n = $urandom_range(0, 4);
      repeat (n) push(rand_desc(), (exp_q.size() < 8) ? 1'b1 : 1'b0);
      start_frame(8'($urandom));
      m = $urandom_range(0, 5);
      repeat (m) begin
        repeat ($urandom_range(0, 6)) tick();
        if (exp_q.size() < 8) push(rand_desc(), 1'b1);
      end
      end_frame();
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
